// File: rtl/reg_arb.sv
// rtl/reg_arb.sv - round-robin arbiter sharing one register-block port among NUM_REQ requesters; optional ack timeout via REG_ARB_TIMEOUT_EN
module reg_arb #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   req_wr,
  input  logic [8*NUM_REQ-1:0] req_addr,
  input  logic [8*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic                 err,
  output logic [7:0]           rd_data,
  output logic                 sel_en,
  output logic                 wr_rd_s,
  output logic [7:0]           addr,
  output logic [7:0]           wdata,
  input  logic                 ack,
  input  logic [7:0]           reg_rd_data
);

  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] owner;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] cand;
  logic          win_found;
`ifdef REG_ARB_TIMEOUT_EN
  logic [7:0]    tcnt;
`else
  assign err = 1'b0;
`endif

  // Round-robin pick: scan from farthest to nearest after ptr so the nearest active requester is the one left standing.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = IW'((int'(ptr) + off) % NUM_REQ);
      if (req[cand]) begin
        win_idx   = cand;
        win_found = 1'b1;
      end
    end
  end

  // Arbitration FSM: grant, hold the register-block select until ack (or timeout), then one released cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= '0;
      done    <= '0;
      rd_data <= '0;
      sel_en  <= 1'b0;
      wr_rd_s <= 1'b0;
      addr    <= '0;
      wdata   <= '0;
      owner   <= '0;
      ptr     <= IW'(NUM_REQ - 1);
`ifdef REG_ARB_TIMEOUT_EN
      err     <= 1'b0;
      tcnt    <= '0;
`endif
    end else begin
      done <= '0;
`ifdef REG_ARB_TIMEOUT_EN
      err  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          gnt    <= '0;
          sel_en <= 1'b0;
          if (win_found) begin
            owner   <= win_idx;
            gnt     <= NUM_REQ'(1) << win_idx;
            wr_rd_s <= req_wr[win_idx];
            addr    <= req_addr[int'(win_idx)*8 +: 8];
            wdata   <= req_wdata[int'(win_idx)*8 +: 8];
            sel_en  <= 1'b1;
`ifdef REG_ARB_TIMEOUT_EN
            tcnt    <= '0;
`endif
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (ack) begin
            if (!wr_rd_s) begin
              rd_data <= reg_rd_data;
            end
            done   <= gnt;
            sel_en <= 1'b0;
            state  <= RELEASE;
          end
`ifdef REG_ARB_TIMEOUT_EN
          else if (tcnt == 8'(TIMEOUT_CYC - 1)) begin
            rd_data <= 8'hFF;
            done    <= gnt;
            err     <= 1'b1;
            sel_en  <= 1'b0;
            state   <= RELEASE;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
`endif
        end
        RELEASE: begin
          // Select stays low this cycle so the register block drops its write enable before any new owner.
          ptr   <= owner;
          gnt   <= '0;
          state <= IDLE;
        end
        default: begin
          gnt    <= '0;
          sel_en <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
